// File: rtl/bfp16_div_seq.sv
// Multi-cycle BFloat16 divider: special-case decode at accept, then a 9-step
// restoring mantissa division, one normalisation step, and a held result.
module bfp16_div_seq #(
    parameter int SIZE_DATA = 32,
    parameter int BIAS      = 127
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_bfu_div,
    output logic                 o_div_by_zero,
    output logic                 o_nan
);

    localparam logic signed [9:0] BIAS_E = 10'(BIAS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NORM,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d;
    logic [7:0]  eb_q, eb_d;
    logic [7:0]  mb_q, mb_d;
    logic [8:0]  r_q, r_d;
    logic [8:0]  q_q, q_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        dbz_q, dbz_d;
    logic        nan_q, nan_d;

    // Low halves of the containers carry no BF16 information.
    logic unused_low_bits;
    assign unused_low_bits = ^{i_data_a[15:0], i_data_b[15:0]};

    // Operand classification straight from the input bus (used only at accept)
    logic [7:0] a_exp, b_exp;
    logic [6:0] a_man, b_man;
    logic       a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign;

    assign a_exp   = i_data_a[30:23];
    assign b_exp   = i_data_b[30:23];
    assign a_man   = i_data_a[22:16];
    assign b_man   = i_data_b[22:16];
    assign a_zero  = (a_exp == 8'h00);
    assign b_zero  = (b_exp == 8'h00);
    assign a_inf   = (a_exp == 8'hFF) && (a_man == 7'h00);
    assign b_inf   = (b_exp == 8'hFF) && (b_man == 7'h00);
    assign a_nan   = (a_exp == 8'hFF) && (a_man != 7'h00);
    assign b_nan   = (b_exp == 8'hFF) && (b_man != 7'h00);
    assign in_sign = i_data_a[31] ^ i_data_b[31];

    logic        sp_hit, sp_nan, sp_dbz;
    logic [15:0] sp_res;

    always_comb begin
        sp_hit = 1'b1;
        sp_nan = 1'b0;
        sp_dbz = 1'b0;
        sp_res = 16'h0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = 16'h7FC0;
            sp_nan = 1'b1;
        end else if (a_inf) begin
            sp_res = {in_sign, 8'hFF, 7'h00};
        end else if (b_inf) begin
            sp_res = {in_sign, 15'h0000};
        end else if (b_zero) begin
            sp_res = {in_sign, 8'hFF, 7'h00};
            sp_dbz = 1'b1;
        end else if (a_zero) begin
            sp_res = {in_sign, 15'h0000};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Normalisation: a quotient below 1.0 costs one exponent step.
    logic signed [9:0] exp_base, exp_norm;
    logic [6:0]        mant_norm;
    logic [15:0]       norm_res;

    assign exp_base  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_E;
    assign exp_norm  = q_q[8] ? exp_base : (exp_base - 10'sd1);
    assign mant_norm = q_q[8] ? q_q[7:1] : q_q[6:0];

    always_comb begin
        if (exp_norm >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 7'h00};
        end else if (exp_norm <= 10'sd0) begin
            norm_res = {sign_q, 15'h0000};
        end else begin
            norm_res = {sign_q, exp_norm[7:0], mant_norm};
        end
    end

    logic [8:0] mb_ext;
    assign mb_ext = {1'b0, mb_q};

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        mb_d    = mb_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        nan_d   = nan_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sign_d = in_sign;
                    ea_d   = a_exp;
                    eb_d   = b_exp;
                    mb_d   = {1'b1, b_man};
                    r_d    = {2'b01, a_man};
                    q_d    = 9'h000;
                    cnt_d  = 4'd0;
                    dbz_d  = sp_dbz;
                    nan_d  = sp_nan;
                    if (sp_hit) begin
                        res_d   = sp_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // One restoring step per cycle; the remainder stays below mb, so 9 bits suffice.
                if (r_q >= mb_ext) begin
                    q_d = {q_q[7:0], 1'b1};
                    r_d = (r_q - mb_ext) << 1;
                end else begin
                    q_d = {q_q[7:0], 1'b0};
                    r_d = r_q << 1;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                res_d   = norm_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            ea_q    <= 8'h00;
            eb_q    <= 8'h00;
            mb_q    <= 8'h00;
            r_q     <= 9'h000;
            q_q     <= 9'h000;
            cnt_q   <= 4'd0;
            res_q   <= 16'h0000;
            dbz_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mb_q    <= mb_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            nan_q   <= nan_d;
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_valid       = (state_q == S_DONE);
    assign o_bfu_div     = {res_q, {(SIZE_DATA-16){1'b0}}};
    assign o_div_by_zero = dbz_q;
    assign o_nan         = nan_q;

endmodule

// File: tb/tb_bfp16_div_seq.sv
// Self-checking bench for bfp16_div_seq: directed cases, backpressure, reset abort,
// then random operands against an arithmetic reference model.
module tb_bfp16_div_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_bfu_div;
    logic        o_div_by_zero;
    logic        o_nan;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    bfp16_div_seq #(.SIZE_DATA(32), .BIAS(127)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data_a      (i_data_a),
        .i_data_b      (i_data_b),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_bfu_div     (o_bfu_div),
        .o_div_by_zero (o_div_by_zero),
        .o_nan         (o_nan)
    );

    // Reference: {special, nan, div_by_zero, result}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int   ea, eb, fa, fb, ma, mb, q, e, mant;
        logic az, bz, ai, bi, an, bn;
        logic [31:0] res;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:16]);
        fb = int'(b[22:16]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) return {3'b110, 32'h7FC00000};
        if (ai) return {3'b100, s, 8'hFF, 23'h0};
        if (bi) return {3'b100, s, 31'h0};
        if (bz) return {3'b101, s, 8'hFF, 23'h0};
        if (az) return {3'b100, s, 31'h0};
        ma = 128 + fa;
        mb = 128 + fb;
        q  = (ma * 256) / mb;
        e  = ea - eb + 127;
        if (q >= 256) begin
            mant = (q / 2) % 128;
        end else begin
            mant = q % 128;
            e    = e - 1;
        end
        if (e >= 255)     res = {s, 8'hFF, 23'h0};
        else if (e <= 0)  res = {s, 31'h0};
        else              res = {s, 8'(e), 7'(mant), 16'h0};
        return {3'b000, res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division, measure edges from the accept edge to o_valid, then hold/release.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [34:0] exp;
        int          lat;
        exp = model(a, b);
        @(negedge i_clk);
        check("ready_before", {31'h0, o_ready}, 32'h1);
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        @(posedge i_clk);
        #1;
        i_valid  = 1'($urandom_range(0, 1));
        i_data_a = $urandom;
        i_data_b = $urandom;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 30) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        // Specials are visible right after the accept edge; normal ops 10 edges later.
        check("latency", 32'(lat), exp[34] ? 32'd0 : 32'd10);
        check("result", o_bfu_div, exp[31:0]);
        check("nan", {31'h0, o_nan}, {31'h0, exp[33]});
        check("div_by_zero", {31'h0, o_div_by_zero}, {31'h0, exp[32]});
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk);
            #1;
            check("hold_result", o_bfu_div, exp[31:0]);
            check("hold_flags", {30'h0, o_nan, o_div_by_zero}, {30'h0, exp[33:32]});
            check("hold_ready", {31'h0, o_ready}, 32'h0);
            check("hold_valid", {31'h0, o_valid}, 32'h1);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        check("release_valid", {31'h0, o_valid}, 32'h0);
        check("release_ready", {31'h0, o_ready}, 32'h1);
        $display("op a=%h b=%h -> %h nan=%0b dbz=%0b lat=%0d", a, b, o_bfu_div, o_nan, o_div_by_zero, lat);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_data_a = 32'h0;
        i_data_b = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", {31'h0, o_ready}, 32'h1);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_result", o_bfu_div, 32'h0);
        check("rst_flags", {30'h0, o_nan, o_div_by_zero}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_op(32'h40400000, 32'h3FC00000, 0);
        check("dir_3_over_1p5", o_bfu_div, 32'h40000000);
        run_op(32'h3F800000, 32'h40400000, 1);
        run_op(32'h3F800000, 32'h00000000, 0);
        run_op(32'h00000000, 32'h00000000, 0);
        run_op(32'hBF800000, 32'h7F800000, 0);
        run_op(32'h7F000000, 32'h3E800000, 0);
        run_op(32'h00800000, 32'h4B000000, 0);
        run_op(32'hC0400000, 32'h3F800000, 5);

        // Reset while CALC has completed four steps: outputs drop at once, no result follows.
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_data_a = 32'h40E00000;
        i_data_b = 32'h40400000;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("abort_valid", {31'h0, o_valid}, 32'h0);
        check("abort_ready", {31'h0, o_ready}, 32'h1);
        check("abort_result", o_bfu_div, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (12) @(posedge i_clk);
        #1;
        check("abort_no_output", {31'h0, o_valid}, 32'h0);
        run_op(32'h40E00000, 32'h40400000, 0);

        for (int k = 0; k < 40; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) ra[30:23] = 8'h00;
            if (sel == 1) rb[30:23] = 8'h00;
            if (sel == 2) ra[30:23] = 8'hFF;
            if (sel == 3) rb[30:23] = 8'hFF;
            if (sel == 4) ra[29:27] = 3'b000;
            run_op(ra, rb, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
